// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM port controller: bus widths,
// access sizes, RAM direction and FSM states.
package mem_ctrl_pkg;

  localparam int MemAddrBus = 32;
  localparam int RamAddrBus = 17;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic RamRead  = 1'b0;
  localparam logic RamWrite = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StResp  = 2'b11
  } state_e;

  // Byte count of an access; both word encodings map to four bytes.
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    logic [2:0] cnt;
    case (size)
      SizeByte: cnt = 3'd1;
      SizeHalf: cnt = 3'd2;
      default:  cnt = 3'd4;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide synchronous RAM between instruction fetch and the
// MEM stage, serialising 8/16/32-bit accesses into little-endian byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = MemAddrBus,
  parameter int RAM_ADDR_WIDTH = RamAddrBus
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_done,
  output logic [31:0]               if_inst,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [1:0]                mem_size,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [31:0]               mem_wdata,
  output logic                      mem_done,
  output logic [31:0]               mem_rdata,
  input  logic [7:0]                ram_din,
  output logic [7:0]                ram_dout,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_wr,
  output logic                      busy
);

  state_e                    state_r;
  state_e                    state_nxt_s;
  logic                      owner_mem_r;
  logic [2:0]                nbytes_r;
  logic [2:0]                cyc_r;
  logic [RAM_ADDR_WIDTH-1:0] base_r;
  logic [31:0]               wdata_r;
  logic [31:0]               asm_r;
  logic [31:0]               asm_nxt_s;
  logic [7:0]                wbyte_s;
  logic [RAM_ADDR_WIDTH-1:0] next_addr_s;
  logic                      unused_addr_s;

  // Only the low address bits reach the RAM; modulo wrap of the full
  // address is identical in those bits, so the upper bits are not kept.
  assign unused_addr_s = ^{if_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                           mem_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH]};

  // cyc_r counts cycles since the grant, so it is also the next byte index.
  assign next_addr_s = base_r + RAM_ADDR_WIDTH'(cyc_r);

  // Next-state logic; MEM wins arbitration, RESP never grants.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      StIdle: begin
        if (mem_req) begin
          state_nxt_s = (mem_we == RamWrite) ? StWrite : StRead;
        end else if (if_req) begin
          state_nxt_s = StRead;
        end else begin
          state_nxt_s = StIdle;
        end
      end
      StRead: begin
        if (cyc_r == (nbytes_r + 3'd1)) begin
          state_nxt_s = StResp;
        end else begin
          state_nxt_s = StRead;
        end
      end
      StWrite: begin
        if (cyc_r == nbytes_r) begin
          state_nxt_s = StResp;
        end else begin
          state_nxt_s = StWrite;
        end
      end
      StResp:  state_nxt_s = StIdle;
      default: state_nxt_s = StIdle;
    endcase
  end

  // Byte k of a read lands on ram_din in cycle k+2, i.e. while cyc_r == k+2.
  always_comb begin
    asm_nxt_s = asm_r;
    case (cyc_r)
      3'd2:    asm_nxt_s[7:0]   = ram_din;
      3'd3:    asm_nxt_s[15:8]  = ram_din;
      3'd4:    asm_nxt_s[23:16] = ram_din;
      3'd5:    asm_nxt_s[31:24] = ram_din;
      default: asm_nxt_s        = asm_r;
    endcase
  end

  // Store byte to present in the next cycle.
  always_comb begin
    wbyte_s = wdata_r[7:0];
    case (cyc_r)
      3'd1:    wbyte_s = wdata_r[15:8];
      3'd2:    wbyte_s = wdata_r[23:16];
      3'd3:    wbyte_s = wdata_r[31:24];
      default: wbyte_s = wdata_r[7:0];
    endcase
  end

  // State, request latches and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= StIdle;
      owner_mem_r <= 1'b0;
      nbytes_r    <= 3'd0;
      cyc_r       <= 3'd0;
      base_r      <= '0;
      wdata_r     <= 32'd0;
      asm_r       <= 32'd0;
      if_done     <= 1'b0;
      if_inst     <= 32'd0;
      mem_done    <= 1'b0;
      mem_rdata   <= 32'd0;
      ram_dout    <= 8'd0;
      ram_addr    <= '0;
      ram_wr      <= RamRead;
      busy        <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      busy     <= (state_nxt_s != StIdle);
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state_r)
        StIdle: begin
          cyc_r <= 3'd1;
          asm_r <= 32'd0;
          if (mem_req) begin
            owner_mem_r <= 1'b1;
            nbytes_r    <= size_to_count(mem_size);
            base_r      <= mem_addr[RAM_ADDR_WIDTH-1:0];
            wdata_r     <= mem_wdata;
            ram_addr    <= mem_addr[RAM_ADDR_WIDTH-1:0];
            ram_dout    <= mem_wdata[7:0];
            ram_wr      <= mem_we;
          end else if (if_req) begin
            owner_mem_r <= 1'b0;
            nbytes_r    <= 3'd4;
            base_r      <= if_addr[RAM_ADDR_WIDTH-1:0];
            ram_addr    <= if_addr[RAM_ADDR_WIDTH-1:0];
            ram_wr      <= RamRead;
          end else begin
            ram_wr <= RamRead;
          end
        end
        StRead: begin
          cyc_r <= cyc_r + 3'd1;
          asm_r <= asm_nxt_s;
          ram_wr <= RamRead;
          if (cyc_r < nbytes_r) begin
            ram_addr <= next_addr_s;
          end
          if (state_nxt_s == StResp) begin
            if (owner_mem_r) begin
              mem_rdata <= asm_nxt_s;
              mem_done  <= 1'b1;
            end else begin
              if_inst <= asm_nxt_s;
              if_done <= 1'b1;
            end
          end
        end
        StWrite: begin
          cyc_r <= cyc_r + 3'd1;
          if (cyc_r < nbytes_r) begin
            ram_addr <= next_addr_s;
            ram_dout <= wbyte_s;
            ram_wr   <= RamWrite;
          end else begin
            ram_wr   <= RamRead;
            mem_done <= 1'b1;
          end
        end
        StResp: begin
          ram_wr <= RamRead;
        end
        default: begin
          ram_wr <= RamRead;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte RAM model; cycle numbers
// count from the request cycle (cycle 0, grant at its closing edge).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [16:0] ram_addr;
  logic        ram_wr;
  logic        busy;

  logic [7:0]  ram_mem [0:131071];
  int          checks_cnt = 0;
  int          errors_cnt = 0;

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_inst   (if_inst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after the address, write at the edge.
  always @(posedge clk) begin
    if (ram_wr === 1'b1) begin
      ram_mem[ram_addr] <= ram_dout;
    end
    ram_din <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
    ram_mem[17'h00100] = 8'h13; ram_mem[17'h00101] = 8'h05;
    ram_mem[17'h00102] = 8'h10; ram_mem[17'h00103] = 8'h00;
    ram_mem[17'h00021] = 8'h5A;
    ram_mem[17'h00031] = 8'h80; ram_mem[17'h00032] = 8'hFF;
    ram_mem[17'h00200] = 8'h11; ram_mem[17'h00201] = 8'h22;
    ram_mem[17'h00202] = 8'h33; ram_mem[17'h00203] = 8'h44;
    ram_mem[17'h1FFFE] = 8'hA1; ram_mem[17'h1FFFF] = 8'hB2;
    ram_mem[17'h00000] = 8'hC3; ram_mem[17'h00001] = 8'hD4;

    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_addr", {15'd0, ram_addr}, 32'd0);
    check("rst_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    // IF word fetch from 0x100
    if_req = 1'b1; if_addr = 32'h0000_0100;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        check("if_addr", {15'd0, ram_addr}, 32'h100 + 32'(c - 1));
        check("if_wr", {31'd0, ram_wr}, 32'd0);
      end
      check("if_busy", {31'd0, busy}, 32'd1);
      check("if_done", {31'd0, if_done}, (c == 6) ? 32'd1 : 32'd0);
    end
    check("if_inst", if_inst, 32'h0010_0513);
    if_req = 1'b0;
    step();
    check("if_idle_busy", {31'd0, busy}, 32'd0);
    check("if_done_pulse", {31'd0, if_done}, 32'd0);
    check("if_inst_hold", if_inst, 32'h0010_0513);

    // Unaligned half load from 0x31
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b01; mem_addr = 32'h31;
    step(); check("lh_addr0", {15'd0, ram_addr}, 32'h31);
    step(); check("lh_addr1", {15'd0, ram_addr}, 32'h32);
    step(); check("lh_done3", {31'd0, mem_done}, 32'd0);
    step(); check("lh_done4", {31'd0, mem_done}, 32'd1);
    check("lh_rdata", mem_rdata, 32'h0000_FF80);
    check("lh_if_done", {31'd0, if_done}, 32'd0);
    mem_req = 1'b0;
    step();

    // Byte store to 0x20
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_addr = 32'h20; mem_wdata = 32'hAABB_CCDD;
    step();
    check("sb_wr", {31'd0, ram_wr}, 32'd1);
    check("sb_addr", {15'd0, ram_addr}, 32'h20);
    check("sb_dout", {24'd0, ram_dout}, 32'hDD);
    check("sb_done1", {31'd0, mem_done}, 32'd0);
    step();
    check("sb_done2", {31'd0, mem_done}, 32'd1);
    check("sb_wr_off", {31'd0, ram_wr}, 32'd0);
    mem_req = 1'b0;
    step();
    check("sb_ram20", {24'd0, ram_mem[17'h20]}, 32'hDD);
    check("sb_ram21", {24'd0, ram_mem[17'h21]}, 32'h5A);
    check("sb_rdata_hold", mem_rdata, 32'h0000_FF80);

    // Conflict: MEM word load at 0x200 beats IF at 0x100
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    check("cf_mem_first", {15'd0, ram_addr}, 32'h200);
    for (int c = 2; c <= 6; c++) step();
    check("cf_mem_done", {31'd0, mem_done}, 32'd1);
    check("cf_if_wait", {31'd0, if_done}, 32'd0);
    check("cf_rdata", mem_rdata, 32'h4433_2211);
    mem_req = 1'b0;
    step();
    check("cf_idle7", {31'd0, busy}, 32'd0);
    step();
    check("cf_if_addr8", {15'd0, ram_addr}, 32'h100);
    for (int c = 9; c <= 12; c++) step();
    check("cf_if_done12", {31'd0, if_done}, 32'd0);
    step();
    check("cf_if_done13", {31'd0, if_done}, 32'd1);
    check("cf_if_inst", if_inst, 32'h0010_0513);
    if_req = 1'b0;
    step();

    // Reset in the middle of a word store to 0x40
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b11; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
    step();
    step();
    check("rs_dout2", {24'd0, ram_dout}, 32'hBE);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_req = 1'b0;
    check("rs_wr", {31'd0, ram_wr}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_done3", {31'd0, mem_done}, 32'd0);
    step();
    check("rs_done4", {31'd0, mem_done}, 32'd0);
    check("rs_ram40", {ram_mem[17'h43], ram_mem[17'h42], ram_mem[17'h41], ram_mem[17'h40]}, 32'h0000_BEEF);

    // Word load wrapping past the top of the address space
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'hFFFF_FFFE;
    step(); check("wr_addr0", {15'd0, ram_addr}, 32'h1FFFE);
    step(); check("wr_addr1", {15'd0, ram_addr}, 32'h1FFFF);
    step(); check("wr_addr2", {15'd0, ram_addr}, 32'h00000);
    step(); check("wr_addr3", {15'd0, ram_addr}, 32'h00001);
    step(); check("wr_done5", {31'd0, mem_done}, 32'd0);
    step(); check("wr_done6", {31'd0, mem_done}, 32'd1);
    check("wr_rdata", mem_rdata, 32'hD4C3_B2A1);
    mem_req = 1'b0;
    step();
    check("wr_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbitrates a single byte-wide synchronous RAM port between instruction fetch (IF) and the MEM stage (loads and stores).
Serialises each 8/16/32-bit access into byte transfers, assembles read data little-endian, and returns a one-cycle done pulse to the requester.
Sits between pc_reg/if_id, mem and the external RAM.
The pipeline stall controller consumes busy and the done pulses.

Parameters:
ADDR_WIDTH, 32, width of the requester byte addresses.
RAM_ADDR_WIDTH, 17, width of the RAM address; ram_addr is the low bits of the current byte address.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
if_req  in  1  instruction fetch request; held until if_done.
if_addr  in  ADDR_WIDTH  fetch byte address.
if_done  out  1  one-cycle pulse; if_inst valid in the same cycle.
if_inst  out  32  fetched word.
mem_req  in  1  load/store request; held until mem_done.
mem_we  in  1  1 = store, 0 = load.
mem_size  in  2  00 = byte, 01 = half, 10 and 11 = word.
mem_addr  in  ADDR_WIDTH  load/store byte address.
mem_wdata  in  32  store data; low bytes used for byte/half.
mem_done  out  1  one-cycle completion pulse.
mem_rdata  out  32  load data, zero-extended; sign extension is done in mem.
ram_din  in  8  RAM read byte; valid the cycle after its address.
ram_dout  out  8  RAM write byte.
ram_addr  out  RAM_ADDR_WIDTH  RAM byte address.
ram_wr  out  1  1 = write, 0 = read.
busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst=1 at an edge): FSM -> IDLE. All outputs are registered and go to 0: if_done, mem_done, if_inst, mem_rdata, ram_dout, ram_addr, ram_wr, busy.
- Reset mid-operation abandons the transfer immediately. A partially written store stays partial; no done pulse is issued. rst has priority over any request on the same edge.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE, arbitration on each edge:
  - mem_req=1 -> grant MEM; latch addr, size, we, wdata; byte count N = 1, 2 or 4.
  - else if_req=1 -> grant IF with N=4, read.
  - Simultaneous requests: MEM wins and IF waits. No preemption once a transfer is granted.
- Inputs are latched at grant and ignored until done. A requester dropping req mid-transfer does not abort it.
- Timing: the grant edge is at the end of cycle 0.
- READ:
  - Cycle k+1 (k = 0..N-1): ram_addr = addr+k, ram_wr=0.
  - Byte k arrives on ram_din in cycle k+2 and is captured into bits [8k+7:8k].
  - After the last address, ram_addr holds with ram_wr=0.
  - Upper unused bytes are 0.
  - The capture of byte N-1 moves the FSM to RESP, so done is high in cycle N+2 (word read: cycle 6).
- WRITE:
  - Cycle k+1: ram_addr = addr+k, ram_dout = wdata[8k+7:8k], ram_wr=1.
  - After byte N-1: ram_wr=0 and FSM -> RESP, so done is high in cycle N+1 (word store: cycle 5).
  - mem_rdata is unchanged by stores.
- RESP: exactly one cycle.
  - The matching done output is 1 and the read data is valid.
  - No new grant is made in RESP, so a requester seeing done must drop req by the next cycle.
  - Next state is IDLE, and arbitration resumes there.
- if_inst and mem_rdata hold their last value between transfers.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH. No alignment check; unaligned accesses are legal and just use consecutive bytes.
- Back-to-back throughput: word read every 7 cycles (grant, 4 address cycles, last data, RESP).

Decomposition:
- The shared defines header gains:
  - size encodings (SizeByte, SizeHalf, SizeWord);
  - FSM state encodings;
  - RamRead/RamWrite constants;
  - MemAddrBus and RamAddrBus widths.
- Single module. The byte counter, the address incrementer and the assembly shift register are in-module; no sub-module is warranted.

Test Plan:
- IF only: if_addr=0x100, RAM[0x100..0x103]=13,05,10,00 -> ram_addr 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_inst=0x00100513.
- Store byte: mem_we=1, size=00, addr=0x20, wdata=0xAABBCCDD -> one write of 0xDD at 0x20 in cycle 1; mem_done in cycle 2; RAM[0x21] untouched.
- Load half, unaligned: addr=0x31, RAM[0x31]=0x80, RAM[0x32]=0xFF -> mem_rdata=0x0000FF80; mem_done in cycle 4.
- Conflict: if_req and mem_req both rise in cycle 0, mem word load -> MEM served first (mem_done cycle 6). IF is granted in the IDLE following RESP, and if_done comes 6 cycles after that grant.
- Reset mid-store: word store to 0x40 with rst=1 at the end of cycle 2 -> only 0x40 and 0x41 are written, ram_wr=0 from cycle 3, no mem_done, busy=0.
- Wrap: mem word load at addr 0xFFFFFFFE -> byte addresses FFFFFFFE, FFFFFFFF, 0, 1 (ram_addr low 17 bits: 1FFFE, 1FFFF, 0, 1).
